// File: rtl/prog_loader_pkg.sv
// Purpose: shared state encoding and default widths for the program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_loader_pkg;

    localparam int IW_DEF = 16;   // instruction word width, always two bytes
    localparam int AW_DEF = 10;   // instruction memory address width
    localparam int LEN_W  = 16;   // word-count field width in the stream header

    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        WRITE   = 3'd4,
        RUN     = 3'd5,
        ERR     = 3'd6
    } state_t;

    // States in which the loader takes a byte from the stream.
    function automatic logic is_rx_state(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO);
    endfunction

endpackage

// File: rtl/prog_loader_byte_pair_asm.sv
// Purpose: joins a captured high byte with the live low byte into one instruction word.
// Latency: hi byte registered on hi_en; word_dat/word_vld are combinational on the lo byte.
// Backpressure: none; the caller decides when each byte is taken.
//
// Ports: clk, reset (sync, active-high); byte_dat incoming byte; hi_en captures it as
// the upper half; lo_en marks the low byte; word_dat = {hi, byte_dat}; word_vld = lo_en.
module prog_loader_byte_pair_asm #(
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    byte_dat,
    input  logic          hi_en,
    input  logic          lo_en,
    output logic [IW-1:0] word_dat,
    output logic          word_vld
);

    logic [7:0] hi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 8'h00;
        end else if (hi_en) begin
            hi_q <= byte_dat;
        end
    end

    assign word_dat = {hi_q, byte_dat};
    assign word_vld = lo_en;

endmodule

// File: rtl/prog_loader.sv
// Purpose: boot loader; parses a 16-bit word count plus that many 16-bit words from a byte stream into imem, holding the CPU in reset until done.
// Latency: imem_we pulses the cycle after a word's low byte is accepted; cpu_reset drops the cycle after the last write.
// Backpressure: rx_ready is a pure state decode; it drops for the write cycle and in RUN/ERR.
//
// Ports: clk, reset (sync, active-high); rx_data/rx_valid/rx_ready byte stream;
// load_req restarts a load from RUN/ERR; imem_we/imem_addr/imem_wdata memory write port;
// cpu_reset, busy, err_len (sticky oversize count), words_loaded (words written this load).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic          load_req,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [IW-1:0] imem_wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          err_len,
    output logic [AW:0]   words_loaded
);

    // Largest legal word count is the full memory depth.
    localparam logic [LEN_W:0] CAP = (LEN_W+1)'(1) << AW;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [AW:0]      wl_q, wl_d;
    logic             err_q, err_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [IW-1:0]    wdata_q, wdata_d;

    logic             accept;
    logic             hi_en;
    logic             lo_en;
    logic [IW-1:0]    word_dat;
    logic             word_vld;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W:0]   wl_inc;

    assign rx_ready = is_rx_state(state_q);
    assign accept   = rx_valid && rx_ready;
    assign hi_en    = accept && (state_q == DATA_HI);
    assign lo_en    = accept && (state_q == DATA_LO);

    // Complete count as it would stand once the low byte in LEN_LO lands.
    assign len_full = {len_q[LEN_W-1:8], rx_data};
    assign wl_inc   = (LEN_W+1)'(wl_q) + (LEN_W+1)'(1);

    prog_loader_byte_pair_asm #(
        .IW (IW)
    ) u_pair (
        .clk      (clk),
        .reset    (reset),
        .byte_dat (rx_data),
        .hi_en    (hi_en),
        .lo_en    (lo_en),
        .word_dat (word_dat),
        .word_vld (word_vld)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wl_d    = wl_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            LEN_HI: begin
                if (accept) begin
                    len_d[LEN_W-1:8] = rx_data;
                    state_d          = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    if (len_full == '0) begin
                        state_d = RUN;
                    end else if ({1'b0, len_full} > CAP) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (word_vld) begin
                    wdata_d = word_dat;
                    addr_d  = wl_q[AW-1:0];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Count is wide enough to reach 2^AW, so a full-memory load never wraps.
                wl_d    = wl_q + 1'b1;
                state_d = (wl_inc == {1'b0, len_q}) ? RUN : DATA_HI;
            end
            RUN, ERR: begin
                if (load_req) begin
                    state_d = LEN_HI;
                    wl_d    = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = LEN_HI;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LEN_HI;
            len_q   <= '0;
            wl_q    <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wl_q    <= wl_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we      = (state_q == WRITE);
    assign cpu_reset    = (state_q != RUN);
    assign busy         = (state_q != RUN) && (state_q != ERR);
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign err_len      = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
// Purpose: directed self-checking bench for prog_loader.
// Latency: n/a.
// Backpressure: byte driver waits on rx_ready with a bounded cycle budget.
module tb_prog_loader;

    localparam int IW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          load_req;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          err_len;
    logic [AW:0]   words_loaded;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Write log filled by the monitor.
    int            wr_n = 0;
    logic [AW-1:0] wr_addr [2048];
    logic [IW-1:0] wr_data [2048];
    int            wr_cyc  [2048];
    int            b2b_cnt = 0;
    logic          prev_we = 1'b0;
    logic          prev_cr = 1'b1;
    int            cr_fall_cyc = -1;

    prog_loader #(.IW(IW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .err_len      (err_len),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_n < 2048) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
        if (prev_we && (imem_we === 1'b1)) b2b_cnt++;
        prev_we = (imem_we === 1'b1);
        if (prev_cr && (cpu_reset === 1'b0)) cr_fall_cyc = cyc;
        prev_cr = (cpu_reset !== 1'b0);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Presents one byte after an optional idle gap and returns #1 after the edge that takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (rx_ready !== 1'b1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        vecs++;
        if (rx_ready !== 1'b1) begin
            errs++;
            $display("FAIL send_byte_timeout: rx_ready=%b after %0d cycles, required 1", rx_ready, guard);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        load_req = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        vecs++; if (rx_ready !== 1'b1) begin errs++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        vecs++; if (imem_we !== 1'b0) begin errs++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
        vecs++; if (imem_addr !== 10'd0) begin errs++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
        vecs++; if (imem_wdata !== 16'h0000) begin errs++; $display("FAIL reset_imem_wdata: got %h want 0", imem_wdata); end
        vecs++; if (cpu_reset !== 1'b1) begin errs++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL reset_busy: got %b want 1", busy); end
        vecs++; if (err_len !== 1'b0) begin errs++; $display("FAIL reset_err_len: got %b want 0", err_len); end
        vecs++; if (words_loaded !== 11'd0) begin errs++; $display("FAIL reset_words_loaded: got %0d want 0", words_loaded); end
    endtask

    task automatic test_basic();
        int base;
        int t_lo;
        base = wr_n;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        t_lo = cyc;
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        idle(3);
        vecs++; if (wr_n - base !== 2) begin errs++; $display("FAIL basic_write_count: got %0d want 2", wr_n - base); end
        vecs++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 16'h1234) begin errs++; $display("FAIL basic_write0: got addr %0d data %h want addr 0 data 1234", wr_addr[base], wr_data[base]); end
        vecs++; if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 16'hABCD) begin errs++; $display("FAIL basic_write1: got addr %0d data %h want addr 1 data abcd", wr_addr[base+1], wr_data[base+1]); end
        vecs++; if (wr_cyc[base] !== t_lo) begin errs++; $display("FAIL basic_first_latency: write in cycle %0d want %0d", wr_cyc[base], t_lo); end
        vecs++; if (cr_fall_cyc !== wr_cyc[base+1] + 1) begin errs++; $display("FAIL basic_cpu_reset_fall: fell in cycle %0d want %0d", cr_fall_cyc, wr_cyc[base+1] + 1); end
        vecs++; if (words_loaded !== 11'd2) begin errs++; $display("FAIL basic_words_loaded: got %0d want 2", words_loaded); end
        vecs++; if (cpu_reset !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin errs++; $display("FAIL basic_run_outputs: cpu_reset=%b busy=%b rx_ready=%b want 0 0 0", cpu_reset, busy, rx_ready); end
    endtask

    task automatic test_zero_len();
        int base;
        pulse_load_req();
        base = wr_n;
        send_byte(8'h00, 0);
        vecs++; if (cpu_reset !== 1'b1) begin errs++; $display("FAIL zero_len_lo_cpu_reset: got %b want 1", cpu_reset); end
        send_byte(8'h00, 0);
        vecs++; if (cpu_reset !== 1'b0) begin errs++; $display("FAIL zero_len_cpu_reset: got %b want 0", cpu_reset); end
        idle(3);
        vecs++; if (wr_n - base !== 0) begin errs++; $display("FAIL zero_len_writes: got %0d want 0", wr_n - base); end
        vecs++; if (words_loaded !== 11'd0 || busy !== 1'b0) begin errs++; $display("FAIL zero_len_state: words_loaded=%0d busy=%b want 0 0", words_loaded, busy); end
    endtask

    task automatic test_len_err();
        pulse_load_req();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        rx_data = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (err_len !== 1'b1) begin errs++; $display("FAIL len_err_flag: got %b want 1", err_len); end
        vecs++; if (cpu_reset !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL len_err_state: cpu_reset=%b rx_ready=%b busy=%b want 1 0 0", cpu_reset, rx_ready, busy); end
        rx_valid = 1'b0;
        pulse_load_req();
        vecs++; if (err_len !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL len_err_clear: err_len=%b rx_ready=%b busy=%b want 0 1 1", err_len, rx_ready, busy); end
    endtask

    task automatic test_gaps();
        int base;
        int b2b0;
        logic [7:0] bytes [8];
        bytes = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFF, 8'hFF};
        base = wr_n;
        b2b0 = b2b_cnt;
        for (int i = 0; i < 8; i++) send_byte(bytes[i], int'($urandom_range(0, 3)));
        idle(4);
        vecs++; if (wr_n - base !== 3) begin errs++; $display("FAIL gaps_write_count: got %0d want 3", wr_n - base); end
        vecs++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 16'h0001) begin errs++; $display("FAIL gaps_write0: got addr %0d data %h want 0 0001", wr_addr[base], wr_data[base]); end
        vecs++; if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 16'h0002) begin errs++; $display("FAIL gaps_write1: got addr %0d data %h want 1 0002", wr_addr[base+1], wr_data[base+1]); end
        vecs++; if (wr_addr[base+2] !== 10'd2 || wr_data[base+2] !== 16'hFFFF) begin errs++; $display("FAIL gaps_write2: got addr %0d data %h want 2 ffff", wr_addr[base+2], wr_data[base+2]); end
        vecs++; if (b2b_cnt - b2b0 !== 0) begin errs++; $display("FAIL gaps_back_to_back_we: got %0d want 0", b2b_cnt - b2b0); end
        vecs++; if (words_loaded !== 11'd3 || cpu_reset !== 1'b0) begin errs++; $display("FAIL gaps_done: words_loaded=%0d cpu_reset=%b want 3 0", words_loaded, cpu_reset); end
    endtask

    task automatic test_full_len();
        int base;
        int bad;
        logic [15:0] w;
        pulse_load_req();
        base = wr_n;
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            w = 16'(i * 7 + 3);
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
        end
        idle(3);
        bad = 0;
        for (int j = 0; j < 1024; j++) begin
            w = 16'(j * 7 + 3);
            if (wr_addr[base+j] !== AW'(j) || wr_data[base+j] !== w) bad++;
        end
        vecs++; if (wr_n - base !== 1024) begin errs++; $display("FAIL full_write_count: got %0d want 1024", wr_n - base); end
        vecs++; if (bad !== 0) begin errs++; $display("FAIL full_write_contents: %0d bad writes want 0", bad); end
        vecs++; if (wr_addr[base+1023] !== 10'h3FF) begin errs++; $display("FAIL full_last_addr: got %h want 3ff", wr_addr[base+1023]); end
        vecs++; if (words_loaded !== 11'd1024) begin errs++; $display("FAIL full_words_loaded: got %0d want 1024", words_loaded); end
        vecs++; if (cpu_reset !== 1'b0 || err_len !== 1'b0) begin errs++; $display("FAIL full_run: cpu_reset=%b err_len=%b want 0 0", cpu_reset, err_len); end
    endtask

    task automatic test_reset_mid();
        int base;
        pulse_load_req();
        base = wr_n;
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        idle(1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vecs++; if (cpu_reset !== 1'b1 || rx_ready !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL mid_reset_state: cpu_reset=%b rx_ready=%b busy=%b want 1 1 1", cpu_reset, rx_ready, busy); end
        vecs++; if (words_loaded !== 11'd0) begin errs++; $display("FAIL mid_reset_words: got %0d want 0", words_loaded); end
        idle(5);
        vecs++; if (wr_n - base !== 1) begin errs++; $display("FAIL mid_reset_writes: got %0d want 1", wr_n - base); end
        base = wr_n;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        idle(3);
        vecs++; if (wr_n - base !== 1 || wr_addr[base] !== 10'd0 || wr_data[base] !== 16'h7788) begin errs++; $display("FAIL mid_reset_reload: count %0d addr %0d data %h want 1 0 7788", wr_n - base, wr_addr[base], wr_data[base]); end
        vecs++; if (cpu_reset !== 1'b0) begin errs++; $display("FAIL mid_reset_run: cpu_reset=%b want 0", cpu_reset); end
    endtask

    task automatic test_reload_ignore();
        int base;
        pulse_load_req();
        vecs++; if (cpu_reset !== 1'b1 || words_loaded !== 11'd0) begin errs++; $display("FAIL reload_restart: cpu_reset=%b words_loaded=%0d want 1 0", cpu_reset, words_loaded); end
        base = wr_n;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h5A, 0);
        rx_valid = 1'b0;
        pulse_load_req();
        vecs++; if (busy !== 1'b1 || rx_ready !== 1'b1) begin errs++; $display("FAIL reload_ignored_midload: busy=%b rx_ready=%b want 1 1", busy, rx_ready); end
        send_byte(8'h5A, 0);
        idle(3);
        vecs++; if (wr_n - base !== 1 || wr_addr[base] !== 10'd0 || wr_data[base] !== 16'h5A5A) begin errs++; $display("FAIL reload_write: count %0d addr %0d data %h want 1 0 5a5a", wr_n - base, wr_addr[base], wr_data[base]); end
        vecs++; if (cpu_reset !== 1'b0 || words_loaded !== 11'd1) begin errs++; $display("FAIL reload_run: cpu_reset=%b words_loaded=%0d want 0 1", cpu_reset, words_loaded); end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_len_err();
        test_gaps();
        test_full_len();
        test_reset_mid();
        test_reload_ignore();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
